// File: rtl/data_memory_responder.sv
// data_memory_responder: two-port wait-state data memory (port 1 memRead/memWrite/address/writeData -> readData/memReady/addrError; port 2 memRead2/address2 -> readData2/memReady2/addrError2)
module data_memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  memReady,
  output logic                  addrError,
  input  logic                  memRead2,
  input  logic [31:0]           address2,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic                  memReady2,
  output logic                  addrError2
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH] = '{default: '0};
  state_t st1, st1_nx, st2, st2_nx;
  logic [3:0] cnt1, cnt2;
  logic [ADDR_WIDTH+1:0] a1, a2;
  logic [DATA_WIDTH-1:0] wd1;
  logic wr1, acc1, acc2, mis1, mis2, req1, unused_hi;
  assign unused_hi = ^{address[31:ADDR_WIDTH+2], address2[31:ADDR_WIDTH+2]};
  assign req1 = memRead || memWrite;
  assign acc1 = st1 == WAIT && cnt1 == '0;
  assign acc2 = st2 == WAIT && cnt2 == '0;
  assign mis1 = |a1[1:0];
  assign mis2 = |a2[1:0];
  assign memReady = st1 == RESP;
  assign memReady2 = st2 == RESP;
  assign addrError = memReady && mis1;
  assign addrError2 = memReady2 && mis2;
  always_comb st1_nx = st1 == IDLE ? (req1 ? WAIT : IDLE) : st1 == WAIT ? (acc1 ? RESP : WAIT) : IDLE;
  always_comb st2_nx = st2 == IDLE ? (memRead2 ? WAIT : IDLE) : st2 == WAIT ? (acc2 ? RESP : WAIT) : IDLE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      st1 <= IDLE;
      cnt1 <= '0;
      a1 <= '0;
      wd1 <= '0;
      wr1 <= 1'b0;
      readData <= '0;
    end else begin
      st1 <= st1_nx;
      if (st1 == IDLE && req1) begin
        a1 <= address[ADDR_WIDTH+1:0];
        wd1 <= writeData;
        wr1 <= memWrite;
        cnt1 <= WS;
      end else if (st1 == WAIT && !acc1) cnt1 <= cnt1 - 4'd1;
      if (acc1 && !wr1) readData <= mis1 ? '0 : mem[a1[ADDR_WIDTH+1:2]];
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      st2 <= IDLE;
      cnt2 <= '0;
      a2 <= '0;
      readData2 <= '0;
    end else begin
      st2 <= st2_nx;
      if (st2 == IDLE && memRead2) begin
        a2 <= address2[ADDR_WIDTH+1:0];
        cnt2 <= WS;
      end else if (st2 == WAIT && !acc2) cnt2 <= cnt2 - 4'd1;
      if (acc2) readData2 <= mis2 ? '0 : mem[a2[ADDR_WIDTH+1:2]];
    end
  // Array has no reset; port 2 samples it on the same edge, so it sees pre-write data.
  always_ff @(posedge clock)
    if (acc1 && wr1 && !mis1) mem[a1[ADDR_WIDTH+1:2]] <= wd1;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: randomized and directed checks against an edge-scheduled array model
module tb_data_memory_responder;
  localparam int DW = 32, AW = 8, W = 2;
  logic clock = 0, reset = 0, memRead = 0, memWrite = 0, memRead2 = 0;
  logic [31:0] address = 0, address2 = 0;
  logic [DW-1:0] writeData = 0, readData, readData2;
  logic memReady, addrError, memReady2, addrError2;
  int checks = 0, failures = 0, edge_n = 0;
  logic [31:0] ref_mem [2**AW];
  logic [31:0] exp1 = 0, exp2 = 0, p1_d = 0;
  logic [AW-1:0] p1_idx = 0, p2_idx = 0;
  logic p1_wr = 0, p1_mis = 0, p2_mis = 0;
  int p1_edge = -1, p2_edge = -1;
  always #5 clock = ~clock;
  data_memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(W)) dut (
    .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite), .address(address),
    .writeData(writeData), .readData(readData), .memReady(memReady), .addrError(addrError),
    .memRead2(memRead2), .address2(address2), .readData2(readData2), .memReady2(memReady2),
    .addrError2(addrError2)
  );
  initial for (int i = 0; i < 2**AW; i++) ref_mem[i] = 0;
  // Model: each access takes effect at its scheduled edge; port 2 reads before port 1 writes.
  always @(posedge clock) begin
    edge_n++;
    if (!reset) begin
      exp1 = 0;
      exp2 = 0;
    end
    if (p2_edge == edge_n) exp2 = p2_mis ? 0 : ref_mem[p2_idx];
    if (p1_edge == edge_n) begin
      if (p1_wr) begin
        if (!p1_mis) ref_mem[p1_idx] = p1_d;
      end else exp1 = p1_mis ? 0 : ref_mem[p1_idx];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'h0000_0C3C;
    if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction
  task automatic p1_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int acc, n;
    @(negedge clock);
    memRead = rd;
    memWrite = wr;
    address = a;
    writeData = d;
    acc = edge_n + 1;
    p1_wr = wr;
    p1_mis = |a[1:0];
    p1_idx = a[AW+1:2];
    p1_d = d;
    p1_edge = acc + W + 1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        address = $urandom;
        writeData = $urandom;
      end
    end while (!memReady && n < 40);
    check("p1_latency", 32'(edge_n - acc), W + 1);
    check("p1_rdata", readData, exp1);
    check("p1_err", 32'(addrError), 32'(p1_mis));
    memRead = 0;
    memWrite = 0;
    @(negedge clock);
    check("p1_pulse", 32'(memReady), 0);
  endtask
  task automatic p2_op(input logic [31:0] a);
    int acc, n;
    @(negedge clock);
    memRead2 = 1;
    address2 = a;
    acc = edge_n + 1;
    p2_mis = |a[1:0];
    p2_idx = a[AW+1:2];
    p2_edge = acc + W + 1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) address2 = $urandom;
    end while (!memReady2 && n < 40);
    check("p2_latency", 32'(edge_n - acc), W + 1);
    check("p2_rdata", readData2, exp2);
    check("p2_err", 32'(addrError2), 32'(p2_mis));
    memRead2 = 0;
    @(negedge clock);
    check("p2_pulse", 32'(memReady2), 0);
  endtask
  task automatic hold_both();
    int e, n, pulses;
    n = 0;
    pulses = 0;
    @(negedge clock);
    memRead = 1;
    memWrite = 1;
    address = 32'h20;
    writeData = 32'h55;
    e = edge_n + W + 2;
    while (pulses < 3 && n < 60) begin
      @(negedge clock);
      n++;
      if (memReady) begin
        check("hold_edge", 32'(edge_n), 32'(e));
        check("hold_rdata", readData, exp1);
        check("hold_err", 32'(addrError), 0);
        pulses++;
        e = edge_n + W + 3;
      end
    end
    check("hold_pulses", 32'(pulses), 3);
    memRead = 0;
    memWrite = 0;
    ref_mem[8] = 32'h55;
    @(negedge clock);
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_rd1"}, readData, 0);
    check({tag, "_rd2"}, readData2, 0);
    check({tag, "_rdy"}, {30'b0, memReady, memReady2}, 0);
    check({tag, "_err"}, {30'b0, addrError, addrError2}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1;
    p1_op(0, 1, 32'h10, 32'hDEADBEEF);
    p1_op(1, 0, 32'h10, 0);
    check("wr_rd", readData, 32'hDEADBEEF);
    fork
      p1_op(0, 1, 32'h10, 32'h12345678);
      p2_op(32'h10);
    join
    check("collide_old", readData2, 32'hDEADBEEF);
    p2_op(32'h10);
    check("collide_new", readData2, 32'h12345678);
    p1_op(1, 0, 32'h13, 0);
    check("mis_rdata", readData, 0);
    check("mis_rd2_hold", readData2, 32'h12345678);
    p1_op(0, 1, 32'h400, 32'hA5A5A5A5);
    p1_op(1, 0, 32'h0, 0);
    check("alias", readData, 32'hA5A5A5A5);
    hold_both();
    p2_op(32'h20);
    check("both_write", readData2, 32'h55);
    fork
      for (int i = 0; i < 50; i++) begin
        int t;
        t = $urandom_range(0, 2);
        p1_op(t != 1, t != 0, rand_addr(), $urandom);
      end
      for (int i = 0; i < 50; i++) p2_op(rand_addr());
    join
    p1_op(0, 1, 32'h30, 32'h11);
    p1_op(1, 0, 32'h30, 0);
    p2_op(32'h30);
    @(negedge clock);
    memWrite = 1;
    address = 32'h30;
    writeData = 32'h99;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 0;
    #1 check_all_zero("midreset");
    memWrite = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1;
    p1_op(1, 0, 32'h30, 0);
    check("abort_nocommit", readData, 32'h11);
    p2_op(32'h30);
    p2_op(32'h10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
